// File: rtl/branch_target_buffer_pkg.sv
// Shared types for the fetch-stage branch target buffer and its helpers.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package branch_target_buffer_pkg;

  localparam int unsigned BTB_INDEX_WIDTH = 6;
  localparam int unsigned BTB_ADDR_WIDTH  = `ADDR_WIDTH;
  localparam int unsigned BTB_TAG_WIDTH   = BTB_ADDR_WIDTH - BTB_INDEX_WIDTH - 2;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef enum logic {
    BTB_INIT,
    BTB_READY
  } btb_state_t;

  typedef struct packed {
    logic                      valid;
    logic [BTB_TAG_WIDTH-1:0]  tag;
    logic [BTB_ADDR_WIDTH-1:0] target;
    logic                      is_jump;
    logic [1:0]                ctr;
  } btb_entry_t;

endpackage

// File: rtl/btb_sat_counter.sv
// 2-bit saturating counter next-value function, shared by direction predictors.
module btb_sat_counter
  import branch_target_buffer_pkg::*;
(
  input  logic [1:0]   ctr_i,
  input  BranchOutcome outcome_i,
  output logic [1:0]   ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (outcome_i == TAKEN) begin
      if (ctr_i != 2'b11) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != 2'b00) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged BTB: zero-latency next-PC prediction, trained by execute feedback.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = BTB_INDEX_WIDTH,
  parameter int unsigned ADDR_WIDTH  = BTB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  output logic                  o_ready,
  input  logic                  i_lookup_valid,
  input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
  output logic                  o_hit,
  output BranchOutcome          o_prediction,
  output logic [ADDR_WIDTH-1:0] o_next_pc,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic [ADDR_WIDTH-1:0] i_upd_target,
  input  logic                  i_upd_is_jump,
  input  BranchOutcome          i_upd_outcome
);

  localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int unsigned NumEntries = 2 ** INDEX_WIDTH;

  btb_state_t             state_q;
  logic [INDEX_WIDTH-1:0] ptr_q;
  btb_entry_t             entries_q [NumEntries];

  logic [INDEX_WIDTH-1:0] lk_idx, upd_idx;
  logic [TAG_WIDTH-1:0]   lk_tag, upd_tag;
  btb_entry_t             lk_entry, upd_entry, upd_entry_d;
  logic                   lk_taken, upd_en, upd_hit, upd_we;
  logic [1:0]             ctr_next;
  logic                   unused_pc_bits;

  assign unused_pc_bits = ^i_upd_pc[1:0];

  // Only valid bits are swept; tag/target storage carries no reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BTB_INIT;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        BTB_INIT: begin
          if (i_flush) begin
            ptr_q <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
            if (ptr_q == '1) state_q <= BTB_READY;
          end
        end
        BTB_READY: begin
          if (i_flush) begin
            state_q <= BTB_INIT;
            ptr_q   <= '0;
          end
        end
        default: state_q <= BTB_INIT;
      endcase
    end
  end

  assign o_ready = (state_q == BTB_READY);

  // Lookup reads pre-update contents; no write bypass.
  assign lk_idx   = i_lookup_pc[INDEX_WIDTH+1:2];
  assign lk_tag   = i_lookup_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign lk_entry = entries_q[lk_idx];

  always_comb begin
    o_hit        = rst_n & o_ready & i_lookup_valid & lk_entry.valid & (lk_entry.tag == lk_tag);
    lk_taken     = o_hit & (lk_entry.is_jump | lk_entry.ctr[1]);
    o_next_pc    = lk_taken ? lk_entry.target : i_lookup_pc + ADDR_WIDTH'(4);
    o_prediction = lk_taken ? TAKEN : NOT_TAKEN;
  end

  assign upd_idx   = i_upd_pc[INDEX_WIDTH+1:2];
  assign upd_tag   = i_upd_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign upd_entry = entries_q[upd_idx];
  assign upd_en    = rst_n & i_upd_valid & o_ready & ~i_flush;
  assign upd_hit   = upd_entry.valid & (upd_entry.tag == upd_tag);

  btb_sat_counter u_sat_counter (
    .ctr_i     (upd_entry.ctr),
    .outcome_i (i_upd_outcome),
    .ctr_o     (ctr_next)
  );

  always_comb begin
    upd_entry_d = upd_entry;
    upd_we      = 1'b0;
    if (upd_en) begin
      if (upd_hit) begin
        upd_we          = 1'b1;
        upd_entry_d.ctr = ctr_next;
        if (i_upd_outcome == TAKEN) begin
          upd_entry_d.target  = i_upd_target;
          upd_entry_d.is_jump = i_upd_is_jump;
        end
      end else if (i_upd_outcome == TAKEN) begin
        upd_we              = 1'b1;
        upd_entry_d.valid   = 1'b1;
        upd_entry_d.tag     = upd_tag;
        upd_entry_d.target  = i_upd_target;
        upd_entry_d.is_jump = i_upd_is_jump;
        upd_entry_d.ctr     = i_upd_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == BTB_INIT) begin
      entries_q[ptr_q].valid <= 1'b0;
    end else if (upd_we) begin
      entries_q[upd_idx] <= upd_entry_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: sweep timing, counter training, aliasing, flush.
module tb_branch_target_buffer;
  import branch_target_buffer_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_flush;
  logic         o_ready;
  logic         i_lookup_valid;
  logic [31:0]  i_lookup_pc;
  logic         o_hit;
  BranchOutcome o_prediction;
  logic [31:0]  o_next_pc;
  logic         i_upd_valid;
  logic [31:0]  i_upd_pc;
  logic [31:0]  i_upd_target;
  logic         i_upd_is_jump;
  BranchOutcome i_upd_outcome;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  branch_target_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_flush        (i_flush),
    .o_ready        (o_ready),
    .i_lookup_valid (i_lookup_valid),
    .i_lookup_pc    (i_lookup_pc),
    .o_hit          (o_hit),
    .o_prediction   (o_prediction),
    .o_next_pc      (o_next_pc),
    .i_upd_valid    (i_upd_valid),
    .i_upd_pc       (i_upd_pc),
    .i_upd_target   (i_upd_target),
    .i_upd_is_jump  (i_upd_is_jump),
    .i_upd_outcome  (i_upd_outcome)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive a lookup and compare the combinational prediction.
  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] nxt);
    i_lookup_valid = 1'b1;
    i_lookup_pc    = pc;
    #1;
    check({tag, "_hit"}, {31'd0, o_hit}, {31'd0, hit});
    check({tag, "_pred"}, {31'd0, o_prediction}, {31'd0, taken});
    check({tag, "_npc"}, o_next_pc, nxt);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic jmp,
                     input BranchOutcome oc);
    i_upd_valid   = 1'b1;
    i_upd_pc      = pc;
    i_upd_target  = tgt;
    i_upd_is_jump = jmp;
    i_upd_outcome = oc;
    @(posedge clk);
    #1;
    i_upd_valid = 1'b0;
  endtask

  // Counter walk starting from 10 at 0x400: 01,00,00,01,10,11,11,10,01
  BranchOutcome ctr_seq [9] = '{NOT_TAKEN, NOT_TAKEN, NOT_TAKEN, TAKEN, TAKEN, TAKEN, TAKEN,
                                NOT_TAKEN, NOT_TAKEN};
  logic         ctr_tkn [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  int unsigned cnt;

  initial begin
    rst_n          = 1'b0;
    i_flush        = 1'b0;
    i_lookup_valid = 1'b0;
    i_lookup_pc    = '0;
    i_upd_valid    = 1'b0;
    i_upd_pc       = '0;
    i_upd_target   = '0;
    i_upd_is_jump  = 1'b0;
    i_upd_outcome  = NOT_TAKEN;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, o_ready}, 32'd0);
    look("reset_look", 32'h0000_0400, 1'b0, 1'b0, 32'h0000_0404);
    rst_n = 1'b1;

    cnt = 0;
    while (!o_ready && cnt < 200) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("init_sweep_len", cnt, 32'd64);
    look("post_init", 32'h0000_0400, 1'b0, 1'b0, 32'h0000_0404);

    upd(32'h0000_0400, 32'h0000_0480, 1'b0, TAKEN);
    look("alloc", 32'h0000_0400, 1'b1, 1'b1, 32'h0000_0480);

    for (int i = 0; i < 9; i++) begin
      upd(32'h0000_0400, 32'h0000_0480, 1'b0, ctr_seq[i]);
      look($sformatf("ctr%0d", i), 32'h0000_0400, 1'b1, ctr_tkn[i],
           ctr_tkn[i] ? 32'h0000_0480 : 32'h0000_0404);
    end

    i_lookup_valid = 1'b0;
    #1;
    check("lookup_invalid_hit", {31'd0, o_hit}, 32'd0);
    check("lookup_invalid_npc", o_next_pc, 32'h0000_0404);

    // 0x500 aliases index 0 with 0x400
    look("alias_miss", 32'h0000_0500, 1'b0, 1'b0, 32'h0000_0504);
    upd(32'h0000_0500, 32'h0000_0600, 1'b1, TAKEN);
    look("alias_new", 32'h0000_0500, 1'b1, 1'b1, 32'h0000_0600);
    look("alias_old", 32'h0000_0400, 1'b0, 1'b0, 32'h0000_0404);
    upd(32'h0000_0500, 32'h0000_0600, 1'b1, NOT_TAKEN);
    upd(32'h0000_0500, 32'h0000_0600, 1'b1, NOT_TAKEN);
    look("jump_ctr_low", 32'h0000_0500, 1'b1, 1'b1, 32'h0000_0600);

    // Same-cycle lookup and allocating update: lookup sees old contents
    i_upd_valid   = 1'b1;
    i_upd_pc      = 32'h0000_0800;
    i_upd_target  = 32'h0000_0900;
    i_upd_is_jump = 1'b0;
    i_upd_outcome = TAKEN;
    look("same_cycle", 32'h0000_0800, 1'b0, 1'b0, 32'h0000_0804);
    @(posedge clk);
    #1;
    i_upd_valid = 1'b0;
    look("next_cycle", 32'h0000_0800, 1'b1, 1'b1, 32'h0000_0900);

    upd(32'h0000_1004, 32'h0000_2000, 1'b0, TAKEN);
    look("idx1", 32'h0000_1004, 1'b1, 1'b1, 32'h0000_2000);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);
    upd(32'h0000_0C08, 32'h0000_0C00, 1'b0, NOT_TAKEN);
    look("nt_no_alloc", 32'h0000_0C08, 1'b0, 1'b0, 32'h0000_0C0C);

    // Flush, with an update issued late in the sweep
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    check("flush_ready", {31'd0, o_ready}, 32'd0);
    cnt = 0;
    while (!o_ready && cnt < 200) begin
      cnt++;
      if (cnt == 40) begin
        i_upd_valid   = 1'b1;
        i_upd_pc      = 32'h0000_1008;
        i_upd_target  = 32'h0000_3000;
        i_upd_is_jump = 1'b1;
        i_upd_outcome = TAKEN;
      end else begin
        i_upd_valid = 1'b0;
      end
      if (cnt == 1 || cnt == 32) look($sformatf("sweep%0d", cnt), 32'h0000_0800, 1'b0, 1'b0,
                                      32'h0000_0804);
      @(posedge clk);
      #1;
    end
    i_upd_valid = 1'b0;
    check("flush_sweep_len", cnt, 32'd64);
    look("flushed_800", 32'h0000_0800, 1'b0, 1'b0, 32'h0000_0804);
    look("flushed_1004", 32'h0000_1004, 1'b0, 1'b0, 32'h0000_1008);
    look("sweep_upd_dropped", 32'h0000_1008, 1'b0, 1'b0, 32'h0000_100C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
